// File: rtl/gf128_pkg.sv
// rtl/gf128_pkg.sv - shared constants, state type and helpers for the GF(2^128) reducer
package gf128_pkg;

    // Field element width and unreduced carry-less product width.
    localparam int GF_W   = 128;
    localparam int PROD_W = 256;

    // Low-order taps of P(x) = x^128 + x^7 + x^2 + x + 1: x^128 == x^7 + x^2 + x + 1.
    localparam logic [7:0] GHASH_POLY_LOW = 8'h87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fold widths the datapath supports. Each must divide 128, and each must stay
    // at or below 121 so that a folded chunk never lands on or above itself.
    function automatic bit fold_w_legal(input int fold_w);
        return (fold_w == 8) || (fold_w == 16) || (fold_w == 32) || (fold_w == 64);
    endfunction

    // Number of fold cycles per operation.
    function automatic int fold_count(input int fold_w);
        return GF_W / fold_w;
    endfunction

    // Width of the fold counter (at least one bit).
    function automatic int fold_cnt_w(input int fold_w);
        return (fold_count(fold_w) > 1) ? $clog2(fold_count(fold_w)) : 1;
    endfunction

endpackage

// File: rtl/gf128_fold_step.sv
// rtl/gf128_fold_step.sv - one combinational fold of FOLD_W product bits into the lower bits
//
// Ports:
//   r      : current working register R[255:0]
//   cnt    : fold index; the chunk folded is R[k+FOLD_W-1:k], k = 256 - FOLD_W*(cnt+1)
//   r_next : R with that chunk cleared and its x^128 image XORed in below it
module gf128_fold_step
    import gf128_pkg::*;
#(
    parameter int FOLD_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic [PROD_W-1:0] r,
    input  logic [CNT_W-1:0]  cnt,
    output logic [PROD_W-1:0] r_next
);

    // A FOLD_W-wide run of ones at bit 0, used for both extraction and clearing.
    localparam logic [PROD_W-1:0] LOW_MASK = {{(PROD_W - FOLD_W){1'b0}}, {FOLD_W{1'b1}}};

    logic [8:0]        k;
    logic [8:0]        base;
    logic [PROD_W-1:0] chunk_mask;
    logic [PROD_W-1:0] c;
    logic [PROD_W-1:0] fold;

    always_comb begin
        k          = 9'(PROD_W - FOLD_W * (int'(cnt) + 1));
        // k never drops below 128, so base = k - 128 is the power of x that the
        // chunk's x^128 factor reduces onto.
        base       = k - 9'd128;
        chunk_mask = LOW_MASK << k;
        c          = (r >> k) & LOW_MASK;
        fold       = '0;
        for (int j = 0; j < 8; j++) begin
            if (GHASH_POLY_LOW[j]) begin
                fold = fold ^ (c << (base + 9'(j)));
            end
        end
        r_next = (r & ~chunk_mask) ^ fold;
    end

endmodule

// File: rtl/gf128_reduce.sv
// rtl/gf128_reduce.sv - sequential modulo-P(x) reducer of a 256-bit carry-less product
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : product offered;  in_ready : reducer idle and able to accept
//   in_product : unreduced product, bit i = coefficient of x^i (sampled on accept only)
//   out_valid  : result available; out_ready : consumer takes the result
//   out_result : reduced field element, held while out_valid && !out_ready
//   busy       : an operation is folding or waiting to be taken
module gf128_reduce
    import gf128_pkg::*;
#(
    parameter int FOLD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [GF_W-1:0]   out_result,
    output logic              busy
);

    localparam int N     = fold_count(FOLD_W);
    localparam int CNT_W = fold_cnt_w(FOLD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (!fold_w_legal(FOLD_W)) begin : g_bad_fold_w
            $error("gf128_reduce: FOLD_W must be 8, 16, 32 or 64");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] r;
    logic [PROD_W-1:0] r_fold;
    logic              accept;

    gf128_fold_step #(
        .FOLD_W (FOLD_W),
        .CNT_W  (CNT_W)
    ) u_fold_step (
        .r      (r),
        .cnt    (cnt),
        .r_next (r_fold)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = FOLD;
                end
            end
            // Fixed latency: every operation takes all N folds, even if the
            // upper half is already zero.
            FOLD: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are flops decoded from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            r         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            if (accept) begin
                r   <= in_product;
                cnt <= '0;
            end else if (state == FOLD) begin
                r   <= r_fold;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // After the last fold R[255:128] is zero, so the low half is the result.
    assign out_result = r[GF_W-1:0];

endmodule

// File: tb/tb_gf128_reduce.sv
// tb/tb_gf128_reduce.sv - randomized self-checking bench for gf128_reduce at all fold widths
module tb_gf128_reduce;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv   [4];
    logic         irdy [4];
    logic [255:0] ip   [4];
    logic         ov   [4];
    logic         ordy [4];
    logic [127:0] res  [4];
    logic         bsy  [4];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instance g uses FOLD_W = 8 << g: 8, 16, 32, 64.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        gf128_reduce #(.FOLD_W(8 << g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv[g]),
            .in_ready   (irdy[g]),
            .in_product (ip[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_result (res[g]),
            .busy       (bsy[g])
        );
    end

    // Bit-serial reference: x^i for i >= 128 is x^(i-128) * (x^7 + x^2 + x + 1).
    function automatic logic [127:0] ref_reduce(input logic [255:0] p);
        logic [255:0] v;
        v = p;
        for (int i = 255; i >= 128; i--) begin
            if (v[i]) begin
                v = v ^ (256'd1 << i) ^ (256'h87 << (i - 128));
            end
        end
        return v[127:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int n_of(input int idx);
        return 128 / (8 << idx);
    endfunction

    // Offer p for one cycle; returns at the negedge after the accept edge.
    task automatic start_op(input int idx, input logic [255:0] p);
        @(negedge clk);
        iv[idx] = 1'b1;
        ip[idx] = p;
        @(negedge clk);
        iv[idx] = 1'b0;
        ip[idx] = rand256();
    endtask

    // Counts edges from accept until out_valid; gives up at 200.
    task automatic wait_done(input int idx, output int lat);
        lat = 0;
        while (!ov[idx] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input int idx);
        ordy[idx] = 1'b1;
        @(negedge clk);
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({irdy[i], ov[i], bsy[i], res[i]} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
                miscompares++;
                $display("FAIL reset_state w=%0d: got rdy=%b ov=%b busy=%b res=%h want rdy=1 ov=0 busy=0 res=0",
                         8 << i, irdy[i], ov[i], bsy[i], res[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [255:0] p   [3];
        logic [127:0] exp [3];
        logic [127:0] got;
        int lat;
        p[0] = 256'd1 << 128;  exp[0] = 128'h87;
        p[1] = 256'd1 << 255;  exp[1] = 128'h8000_0000_0000_0000_0000_0000_0000_2049;
        p[2] = {128'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98};
        exp[2] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
        for (int t = 0; t < 3; t++) begin
            start_op(2, p[t]);
            wait_done(2, lat);
            got = res[2];
            vectors++;
            if (lat !== 4) begin
                miscompares++;
                $display("FAIL directed_latency %0d: got %0d edges want 4", t, lat);
            end
            vectors++;
            if (got !== exp[t]) begin
                miscompares++;
                $display("FAIL directed_result %0d: got %h want %h", t, got, exp[t]);
            end
            finish_op(2);
        end
    endtask

    task automatic test_random();
        logic [255:0] p;
        logic [127:0] got;
        int lat;
        for (int idx = 0; idx < 4; idx++) begin
            for (int t = 0; t < 12; t++) begin
                p = rand256();
                start_op(idx, p);
                wait_done(idx, lat);
                got = res[idx];
                vectors++;
                if (lat !== n_of(idx)) begin
                    miscompares++;
                    $display("FAIL random_latency w=%0d: got %0d want %0d", 8 << idx, lat, n_of(idx));
                end
                vectors++;
                if (got !== ref_reduce(p)) begin
                    miscompares++;
                    $display("FAIL random_result w=%0d: got %h want %h", 8 << idx, got, ref_reduce(p));
                end
                if (idx == 2) begin
                    vectors++;
                    if (g_dut[2].u_dut.r[255:128] !== 128'h0) begin
                        miscompares++;
                        $display("FAIL done_upper_zero: got %h want 0", g_dut[2].u_dut.r[255:128]);
                    end
                end
                finish_op(idx);
            end
        end
    endtask

    task automatic test_stall();
        logic [255:0] p;
        logic [127:0] want;
        int lat;
        p = rand256();
        want = ref_reduce(p);
        start_op(2, p);
        wait_done(2, lat);
        for (int c = 0; c < 5; c++) begin
            iv[2] = 1'b1;
            ip[2] = rand256();
            @(negedge clk);
            vectors++;
            if ({ov[2], irdy[2], res[2]} !== {1'b1, 1'b0, want}) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: got ov=%b rdy=%b res=%h want ov=1 rdy=0 res=%h",
                         c, ov[2], irdy[2], res[2], want);
            end
        end
        iv[2] = 1'b0;
        finish_op(2);
        @(negedge clk);
        vectors++;
        if ({irdy[2], ov[2], bsy[2]} !== 3'b100) begin
            miscompares++;
            $display("FAIL stall_no_accept: got rdy=%b ov=%b busy=%b want 1 0 0", irdy[2], ov[2], bsy[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] expq[$];
        logic [127:0] want;
        int acc = 0;
        int got_n = 0;
        int last_acc = -1;
        int cyc = 0;
        ordy[2] = 1'b1;
        @(negedge clk);
        while (got_n < 5 && cyc < 300) begin
            if (acc < 5) begin
                iv[2] = 1'b1;
                ip[2] = rand256();
            end else begin
                iv[2] = 1'b0;
            end
            if (iv[2] && irdy[2]) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc !== n_of(2) + 2) begin
                        miscompares++;
                        $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, n_of(2) + 2);
                    end
                end
                last_acc = cyc;
                acc++;
                expq.push_back(ref_reduce(ip[2]));
            end
            if (ov[2]) begin
                want = (expq.size() > 0) ? expq.pop_front() : 128'hx;
                vectors++;
                if (res[2] !== want) begin
                    miscompares++;
                    $display("FAIL b2b_result %0d: got %h want %h", got_n, res[2], want);
                end
                got_n++;
            end
            @(negedge clk);
            cyc++;
        end
        iv[2] = 1'b0;
        ordy[2] = 1'b0;
        vectors++;
        if (got_n !== 5) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results want 5", got_n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [255:0] p;
        logic [127:0] got;
        int lat;
        // Mid-FOLD with cnt == 2.
        start_op(2, rand256());
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (g_dut[2].u_dut.cnt !== 2'd2) begin
            miscompares++;
            $display("FAIL midfold_cnt: got %0d want 2", g_dut[2].u_dut.cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({ov[2], irdy[2], bsy[2], res[2]} !== {3'b010, 128'h0}) begin
            miscompares++;
            $display("FAIL reset_midfold: got ov=%b rdy=%b busy=%b res=%h want 0 1 0 0",
                     ov[2], irdy[2], bsy[2], res[2]);
        end
        // In DONE, with out_ready and in_valid also high: reset wins.
        start_op(2, rand256());
        wait_done(2, lat);
        rst = 1'b1;
        ordy[2] = 1'b1;
        iv[2] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ordy[2] = 1'b0;
        iv[2] = 1'b0;
        vectors++;
        if ({ov[2], irdy[2], bsy[2], res[2]} !== {3'b010, 128'h0}) begin
            miscompares++;
            $display("FAIL reset_done: got ov=%b rdy=%b busy=%b res=%h want 0 1 0 0",
                     ov[2], irdy[2], bsy[2], res[2]);
        end
        p = rand256();
        start_op(2, p);
        wait_done(2, lat);
        got = res[2];
        vectors++;
        if (got !== ref_reduce(p) || lat !== 4) begin
            miscompares++;
            $display("FAIL after_reset_op: got %h lat %0d want %h lat 4", got, lat, ref_reduce(p));
        end
        finish_op(2);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            ip[i] = '0;
            ordy[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gf128_reduce.md
# gf128_reduce

Sequential modular reducer for GF(2^128) GHASH arithmetic. It accepts a 256-bit unreduced carry-less product, as produced by the team's Karatsuba polynomial multiplier, and folds it modulo P(x) = x^128 + x^7 + x^2 + x + 1. The result is the 128-bit field element. It sits directly downstream of the multiplier in the GHASH datapath and uses valid/ready handshakes on both sides.

## Interface
- FOLD_W, 32: bits folded per cycle; legal values 8, 16, 32, 64. N = 128/FOLD_W fold cycles per operation.
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  product offered
- in_ready  output  1  block can accept a product
- in_product  input  256  unreduced polynomial; bit i = coefficient of x^i
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  128  reduced element; bit i = coefficient of x^i
- busy  output  1  high in FOLD or DONE

## Operation
- Single clock domain. Reset is synchronous and active-high on `rst`.
- Working register R[255:0]. Fold counter cnt is 0..N-1.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: R<=in_product, cnt<=0, go to FOLD.
  - FOLD: k = 256 - FOLD_W*(cnt+1), c = R[k+FOLD_W-1:k]. R <= (R with bits [k+FOLD_W-1:k] cleared) ^ (c<<(k-128)) ^ (c<<(k-127)) ^ (c<<(k-126)) ^ (c<<(k-121)). cnt increments. After the fold with cnt==N-1, go to DONE.
  - DONE: out_valid=1, out_result=R[127:0]. On out_ready, go to IDLE.
- Fold results never land at or above the chunk being folded, because FOLD_W<=121. The last chunk, k=128, lands in bits [FOLD_W+6:0], so R[255:128] is zero in DONE. The bench asserts this.
- Latency is fixed at N folds regardless of operand value. There is no early exit when the upper half is zero.
- in_product is sampled only on the accept edge. Later changes are ignored.
- out_result is held stable while out_valid=1 and out_ready=0.
- Illegal FOLD_W triggers an elaboration-time error.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_result=0, state=IDLE, cnt=0, R=0.
- Accept at edge t. FOLD occupies edges t+1..t+N. out_valid rises after edge t+N.
- Result handshake at edge u. in_ready returns to 1 after edge u. Minimum initiation interval is N+2 cycles.
- in_ready is 0 in FOLD and DONE, so in_valid is ignored there. There is no input/output overlap.
- out_valid is registered, and out_result is driven from a register.
- rst=1 at any cycle, including mid-FOLD or in DONE with out_ready=0: all registers go to reset values on that edge and the pending result is discarded.
- rst has priority over a simultaneous in_valid or out_ready.

## Structure
- The shared package `gf128_pkg` holds:
  - GF_W=128
  - PROD_W=256
  - GHASH_POLY_LOW=8'h87 (the x^7+x^2+x+1 taps)
  - the state enum {IDLE, FOLD, DONE}
- One natural sub-module is `gf128_fold_step`: combinational, with inputs R and cnt and output next R. It is parameterised by FOLD_W. The top level holds the FSM, counter and handshake.

## Test plan
- in_product = 1<<128, FOLD_W=32 -> out_result = 128'h87. out_valid rises 4 edges after accept.
- in_product = 1<<255 -> out_result = 128'h8000_0000_0000_0000_0000_0000_0000_2049.
- in_product with upper half 0 and lower half 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98 -> result equals the lower half. Latency is still N.
- Random products for each legal FOLD_W, compared against a bit-serial reference reducer. Hold out_ready=0 for 5 cycles -> out_result stable, in_ready=0, and in_valid pulses are ignored.
- Back-to-back operations with in_valid held high and out_ready=1 -> one accept every N+2 cycles, with results in order.
- Assert rst mid-FOLD (cnt=2) and in DONE -> next cycle out_valid=0, out_result=0, in_ready=1. A subsequent operation produces the correct result.
